// File: rtl/mux_scan_reg.sv
// Registered N-channel W-bit multiplexer with manual select and auto-scan.
// An internal dwell counter steps through the channels while scanning.
module mux_scan_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS*WIDTH-1:0] din_i,
  input  logic [SW-1:0]             sel_i,
  input  logic                      mode_i,
  input  logic                      en_i,
  output logic [WIDTH-1:0]          x_o,
  output logic [SW-1:0]             ch_o,
  output logic                      valid_o,
  output logic                      wrap_o,
  output logic                      err_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] LAST_CH  = SW'(CHANNELS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  x_q;
  logic [SW-1:0]     ch_q;
  logic [CW-1:0]     cnt_q;
  logic              valid_q;
  logic              wrap_q;
  logic              err_q;

  logic              selOk_d;
  logic [SW-1:0]     chAdv_d;
  logic [WIDTH-1:0]  selData_d;
  logic [WIDTH-1:0]  holdData_d;
  logic [WIDTH-1:0]  advData_d;

  // Wrap is an explicit compare so non-power-of-two channel counts work.
  assign selOk_d    = (32'(sel_i) < 32'(CHANNELS));
  assign chAdv_d    = (ch_q == LAST_CH) ? '0 : ch_q + SW'(1);
  assign selData_d  = din_i[int'(sel_i) * WIDTH +: WIDTH];
  assign holdData_d = din_i[int'(ch_q) * WIDTH +: WIDTH];
  assign advData_d  = din_i[int'(chAdv_d) * WIDTH +: WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        cnt_q   <= '0;
      end else if (!mode_i) begin
        state_q <= MANUAL;
        valid_q <= 1'b1;
        cnt_q   <= '0;
        if (selOk_d) begin
          ch_q <= sel_i;
          x_q  <= selData_d;
        end else begin
          x_q   <= holdData_d;
          err_q <= 1'b1;
        end
      end else begin
        state_q <= SCAN;
        valid_q <= 1'b1;
        // The entry edge only restarts the dwell count; the channel is kept.
        if (state_q != SCAN) begin
          cnt_q <= '0;
          x_q   <= holdData_d;
        end else if (cnt_q == LAST_CNT) begin
          cnt_q  <= '0;
          ch_q   <= chAdv_d;
          x_q    <= advData_d;
          wrap_q <= (ch_q == LAST_CH);
        end else begin
          cnt_q <= cnt_q + CW'(1);
          x_q   <= holdData_d;
        end
      end
    end
  end

  assign x_o     = x_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: a 4-channel DWELL=2 instance and a
// 3-channel DWELL=1 instance share stimulus and are checked against a model.
module tb_mux_scan_reg;

  typedef struct packed {
    logic [3:0] x;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
    logic       err;
  } outT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic        en = 1'b0;

  logic [3:0]  x0, x1;
  logic [1:0]  ch0, ch1;
  logic        valid0, valid1, wrap0, wrap1, err0, err1;

  int checks = 0;
  int errors = 0;

  outT expQ0[$];
  outT expQ1[$];

  int         mState[2];
  int         mCh[2];
  int         mCnt[2];
  logic [3:0] mX[2];
  logic       mValid[2];

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .din_i(din), .sel_i(sel), .mode_i(mode), .en_i(en),
    .x_o(x0), .ch_o(ch0), .valid_o(valid0), .wrap_o(wrap0), .err_o(err0)
  );

  mux_scan_reg #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .din_i(din[11:0]), .sel_i(sel), .mode_i(mode), .en_i(en),
    .x_o(x1), .ch_o(ch1), .valid_o(valid1), .wrap_o(wrap1), .err_o(err1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour of one instance for one clock edge.
  task automatic modelStep(input int k, input int nch, input int dw, input logic r,
                           input logic e, input logic m, input int s,
                           input logic [15:0] d, output outT o);
    o.wrap = 1'b0;
    o.err  = 1'b0;
    if (r) begin
      mState[k] = 0; mCh[k] = 0; mCnt[k] = 0; mX[k] = 4'h0; mValid[k] = 1'b0;
    end else if (!e) begin
      mState[k] = 0; mCnt[k] = 0; mValid[k] = 1'b0;
    end else if (!m) begin
      mState[k] = 1; mCnt[k] = 0; mValid[k] = 1'b1;
      if (s < nch) mCh[k] = s;
      else o.err = 1'b1;
      mX[k] = d[mCh[k]*4 +: 4];
    end else begin
      mValid[k] = 1'b1;
      if (mState[k] != 2) begin
        mCnt[k] = 0;
      end else if (mCnt[k] == dw - 1) begin
        mCnt[k] = 0;
        if (mCh[k] == nch - 1) begin
          mCh[k] = 0;
          o.wrap = 1'b1;
        end else begin
          mCh[k] = mCh[k] + 1;
        end
      end else begin
        mCnt[k] = mCnt[k] + 1;
      end
      mState[k] = 2;
      mX[k] = d[mCh[k]*4 +: 4];
    end
    o.x     = mX[k];
    o.ch    = 2'(mCh[k]);
    o.valid = mValid[k];
  endtask

  task automatic compareOut(input int k);
    outT e;
    outT obs;
    string p;
    p = (k == 0) ? "dut0" : "dut1";
    obs = (k == 0) ? outT'({x0, ch0, valid0, wrap0, err0})
                   : outT'({x1, ch1, valid1, wrap1, err1});
    if ((k == 0 && expQ0.size() == 0) || (k == 1 && expQ1.size() == 0)) begin
      checkOutput({p, ".queueEmpty"}, 32'd1, 32'd0);
      return;
    end
    e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
    checkOutput({p, ".x"}, 32'(obs.x), 32'(e.x));
    checkOutput({p, ".ch"}, 32'(obs.ch), 32'(e.ch));
    checkOutput({p, ".valid"}, 32'(obs.valid), 32'(e.valid));
    checkOutput({p, ".wrap"}, 32'(obs.wrap), 32'(e.wrap));
    checkOutput({p, ".err"}, 32'(obs.err), 32'(e.err));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic m,
                               input logic [1:0] s, input logic [15:0] d);
    outT o;
    @(negedge clk);
    rst = r; en = e; mode = m; sel = s; din = d;
    modelStep(0, 4, 2, r, e, m, int'(s), d, o);
    expQ0.push_back(o);
    modelStep(1, 3, 1, r, e, m, int'(s), d, o);
    expQ1.push_back(o);
    @(posedge clk);
    #1;
    compareOut(0);
    compareOut(1);
  endtask

  initial begin
    logic rndMode;
    for (int k = 0; k < 2; k++) begin
      mState[k] = 0; mCh[k] = 0; mCnt[k] = 0; mX[k] = 4'h0; mValid[k] = 1'b0;
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 16'(($urandom)));
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 16'(($urandom)));
    checkOutput("resetX", 32'(x0), 32'h0);
    checkOutput("resetValid", 32'(valid0), 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 16'hDCBA);
    checkOutput("manualX", 32'(x0), 32'hC);
    checkOutput("manualCh", 32'(ch0), 32'd2);
    checkOutput("manualValid", 32'(valid0), 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'hDCBA);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 16'hDCBA);
    checkOutput("oorErr", 32'(err1), 32'd1);
    checkOutput("oorCh", 32'(ch1), 32'd1);
    checkOutput("oorX", 32'(x1), 32'hB);
    checkOutput("inRangeNoErr", 32'(err0), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 16'hDCBA);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'hDCBA);
      checkOutput("scanCh", 32'(ch0), 32'((i - 1) / 2));
      checkOutput("scanNoWrap", 32'(wrap0), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'hDCBA);
    checkOutput("scanWrap", 32'(wrap0), 32'd1);
    checkOutput("scanWrapCh", 32'(ch0), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'hDCBA);
    checkOutput("scanAtLast", 32'(ch0), 32'd3);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'hDCBA);
    checkOutput("switchCh", 32'(ch0), 32'd1);
    checkOutput("switchX", 32'(x0), 32'hB);
    checkOutput("switchNoWrap", 32'(wrap0), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3, 16'h1234);
    checkOutput("idleValid", 32'(valid0), 32'd0);
    checkOutput("idleHoldX", 32'(x0), 32'hB);
    checkOutput("idleHoldCh", 32'(ch0), 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 16'hDCBA);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'hDCBA);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'hDCBA);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'hDCBA);
    checkOutput("rstScanCh", 32'(ch0), 32'd0);
    checkOutput("rstScanX", 32'(x0), 32'h0);
    checkOutput("rstScanWrap", 32'(wrap0), 32'd0);
    checkOutput("rstScanValid", 32'(valid0), 32'd0);

    rndMode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) rndMode = ~rndMode;
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) != 0), rndMode,
                    2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_reg.md
# mux_scan_reg

Parametrised, registered N-channel W-bit multiplexer with two operating modes: manual select and auto-scan. In auto-scan an internal dwell counter steps through the channels. This is the clocked, multi-channel successor to the lab's single-bit gate-level select circuit (X = A·B + B'·C). It sits between parallel data sources and a single display/observation bus in the lab top level.

## Interface
- WIDTH, 4, bit width of each channel and of the output
- CHANNELS, 4, number of input channels (legal range 2 to 16; need not be a power of two)
- DWELL, 2, cycles each channel is held in scan mode (legal minimum 1)
- SW = $clog2(CHANNELS), derived, select and channel-index width
- clk  input  1  single system clock; all state changes on its rising edge
- rst  input  1  reset: synchronous and active-high
- din  input  CHANNELS*WIDTH  channel k occupies din[k*WIDTH +: WIDTH]
- sel  input  SW  manual channel select
- mode  input  1  0 = manual, 1 = auto-scan
- en  input  1  enable; when low, the block idles
- x  output  WIDTH  registered selected data
- ch  output  SW  channel index currently driving x
- valid  output  1  x holds a freshly sampled channel value
- wrap  output  1  one-cycle pulse when scan wraps from CHANNELS-1 to 0
- err  output  1  one-cycle pulse when a manual sel is out of range (sel >= CHANNELS)

## Operation
- FSM states: IDLE, MANUAL, SCAN. All outputs are registered.
- Reset (rst=1 at an edge): state=IDLE; x=0; ch=0; valid=0; wrap=0; err=0; dwell counter cnt=0. rst overrides all other inputs.
- Next-state selection at each edge:
  - en=0 → IDLE
  - en=1 with mode=0 → MANUAL
  - en=1 with mode=1 → SCAN
- Transitions are allowed between any pair of states.
- IDLE: x and ch hold their values; valid=0; cnt=0.
- MANUAL, sel < CHANNELS: ch<=sel; x<=din[sel]; valid=1; err=0.
- MANUAL, sel >= CHANNELS: ch holds; x<=din[ch] (re-sampled from the held channel); valid=1; err=1 for that cycle.
- SCAN:
  - Entry edge, from IDLE or MANUAL: ch holds; cnt<=0; x<=din[ch].
  - Subsequent edges in SCAN, if cnt==DWELL-1: ch<=(ch+1) mod CHANNELS; cnt<=0.
  - Subsequent edges in SCAN, otherwise: cnt<=cnt+1 and ch holds.
  - x always reflects the updated ch: x<=din[ch_next], so x and ch are consistent.
  - valid=1 throughout SCAN.
- wrap=1 only on the edge where ch changes from CHANNELS-1 to 0 inside SCAN; otherwise 0.
- Mode change mid-scan: the next edge enters MANUAL and applies sel. cnt is discarded, not retained.
- en low mid-scan: the next edge enters IDLE. Re-entering SCAN later resumes from the held ch with cnt=0.
- Channel index arithmetic is SW bits wide. Wrap is an explicit compare against CHANNELS-1, never natural overflow, so that non-power-of-two CHANNELS work.

## Timing
- Latency: inputs sampled at edge n appear on x/ch/valid after edge n (one cycle).
- There is no combinational path from any input to any output.
- Scan period: DWELL*CHANNELS cycles per full rotation. wrap is asserted once per rotation.
- DWELL=1: ch advances on every edge after the entry edge.
- Simultaneous events: rst wins over everything. If mode and en change on the same edge, the next-state rule above applies directly.
- err and wrap are never asserted in the same cycle.
- Reset mid-operation: outputs take reset values on the same edge. A pending wrap or err is suppressed.

## Test plan
- Reset: drive rst=1 for 2 cycles with arbitrary din/en/mode → x=0, ch=0, valid=0, wrap=0, err=0 after the first edge.
- Manual select (defaults): din={4'hD,4'hC,4'hB,4'hA}, en=1, mode=0, sel=2 → one edge later x=4'hC, ch=2, valid=1.
- Out-of-range: CHANNELS=3, held ch=1, sel=3 → err=1 for one cycle, ch=1, x=din[1], valid=1.
- Scan rotation (DWELL=2): from ch=0, hold mode=1, en=1 for 8 edges → ch sequence 0,0,1,1,2,2,3,3. The wrap pulse appears on edge 9 (ch=0) only.
- Mode switch and enable:
  - In SCAN at ch=3 with cnt=0, set mode=0, sel=1 → next edge ch=1, x=din[1], no wrap.
  - Then drop en → valid=0, x and ch hold.
- Reset mid-scan: assert rst on the edge where ch would wrap 3→0 → ch=0, x=0, wrap=0, valid=0.
